// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle for mux4_rr_arbiter: four requesters in, one registered word out.
interface mux4_rr_arbiter_if #(parameter int WIDTH = 16);
   logic [3:0]       req;
   logic [3:0]       lock;
   logic [3:0]       ack;
   logic [WIDTH-1:0] d0, d1, d2, d3;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       sel;
   logic [15:0]      xfer_cnt;

   modport master (output req, lock, d0, d1, d2, d3, out_ready,
                   input  ack, out_valid, out_data, sel, xfer_cnt);
   modport slave  (input  req, lock, d0, d1, d2, d3, out_ready,
                   output ack, out_valid, out_data, sel, xfer_cnt);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// 4:1 round-robin arbitrating mux with a one-entry registered output stage.
// Optional owner lock with bounded run length when ARB_LOCK_EN is defined.
module mux4_rr_arbiter #(parameter int WIDTH = 16) (
   input logic               clk,
   input logic               rst_n,
   mux4_rr_arbiter_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_last, r_sel, w_rr_win, w_win;
   logic [WIDTH-1:0] r_data;
   logic [15:0]      r_cnt;
   logic [3:0]       w_ack;
   logic             w_arb, w_xfer, w_lock_win;
   logic [WIDTH-1:0] w_d [4];

   assign w_d[0] = bus.d0;
   assign w_d[1] = bus.d1;
   assign w_d[2] = bus.d2;
   assign w_d[3] = bus.d3;

   // rst_n gate keeps ack low while reset is held, whatever req does
   assign w_arb  = rst_n & (|bus.req) & ((r_state == IDLE) | bus.out_ready);
   assign w_xfer = (r_state == HOLD) & bus.out_ready;

   always_comb begin
      logic [1:0] idx;
      logic       found;
      w_rr_win = r_last;
      found    = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = r_last + 2'(k);
         if (!found && bus.req[idx]) begin
            w_rr_win = idx;
            found    = 1'b1;
         end
      end
   end

`ifdef ARB_LOCK_EN
   logic [1:0] r_lock_run;
   logic       r_lock_force;

   // force set after the fourth locked win: next arbitration must rotate
   assign w_lock_win = bus.lock[r_last] & bus.req[r_last] & ~r_lock_force;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_run   <= 2'd0;
         r_lock_force <= 1'b0;
      end else if (w_arb) begin
         if (w_lock_win) begin
            if (r_lock_run == 2'd3) r_lock_force <= 1'b1;
            else                    r_lock_run   <= r_lock_run + 2'd1;
         end else begin
            r_lock_run   <= 2'd0;
            r_lock_force <= 1'b0;
         end
      end
   end
`else
   logic w_lock_unused;
   assign w_lock_unused = ^bus.lock;
   assign w_lock_win    = 1'b0;
`endif

   assign w_win = w_lock_win ? r_last : w_rr_win;

   always_comb begin
      w_state_nxt = r_state;
      w_ack       = 4'b0000;
      if (w_arb) begin
         w_ack[w_win] = 1'b1;
         w_state_nxt  = HOLD;
      end else if (w_xfer) begin
         w_state_nxt  = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_sel  <= 2'd0;
         r_last <= 2'd3;
      end else if (w_arb) begin
         r_data <= w_d[w_win];
         r_sel  <= w_win;
         r_last <= w_win;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_cnt <= 16'd0;
      else if (w_xfer) r_cnt <= r_cnt + 16'd1;
   end

   assign bus.ack       = w_ack;
   assign bus.out_valid = (r_state == HOLD);
   assign bus.out_data  = r_data;
   assign bus.sel       = r_sel;
   assign bus.xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios plus random traffic
// against a queue-based reference model; a negedge monitor does the comparing.
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux4_rr_arbiter_if #(.WIDTH(W)) bus();
   mux4_rr_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {logic [3:0] ack; logic vld; logic [15:0] cnt;} cyc_t;
   typedef struct {logic [W-1:0] data; logic [1:0] sel;} word_t;

   cyc_t  cq[$];
   word_t dq[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   logic       m_hold;
   int         m_last;
   logic [15:0] m_cnt;
   int         m_lwins;
   int         last_win;
   logic [W-1:0] td [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one call per clock cycle, after inputs settle, predicting this cycle and the next edge.
   task automatic model_step();
      logic [3:0] r;
      logic       ev;
      int         w;
      cyc_t       c;
      word_t      wd;
      r  = bus.req;
      w  = -1;
      ev = (r != 4'b0) && (!m_hold || bus.out_ready);
      if (ev) begin
`ifdef ARB_LOCK_EN
         if (bus.lock[m_last] && r[m_last] && m_lwins < 4) begin
            w = m_last;
            m_lwins++;
         end
`endif
         if (w < 0) begin
            for (int k = 1; k <= 4; k++)
               if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
            m_lwins = 0;
         end
      end
      c.ack = 4'b0;
      if (ev) c.ack[w] = 1'b1;
      c.vld = m_hold;
      c.cnt = m_cnt;
      cq.push_back(c);
      if (m_hold && bus.out_ready) m_cnt = m_cnt + 16'd1;
      if (ev) begin
         wd.data = td[w];
         wd.sel  = 2'(w);
         dq.push_back(wd);
         m_last   = w;
         m_hold   = 1'b1;
         last_win = w;
      end else begin
         last_win = -1;
         if (m_hold && bus.out_ready) m_hold = 1'b0;
      end
   endtask

   task automatic apply(input logic [3:0] r, input logic [3:0] lk, input logic rdy);
      bus.req = r; bus.lock = lk; bus.out_ready = rdy;
      bus.d0 = td[0]; bus.d1 = td[1]; bus.d2 = td[2]; bus.d3 = td[3];
      model_step();
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] lk, input logic rdy);
      @(posedge clk); #1;
      apply(r, lk, rdy);
   endtask

   task automatic drive_ack(input logic [3:0] r, input logic [3:0] lk, input logic rdy,
                            input logic [3:0] exp_ack, input string name);
      drive(r, lk, rdy);
      #1 check(name, 32'(bus.ack), 32'(exp_ack));
   endtask

   // Asserts reset now, checks forced outputs, releases one edge later and applies given inputs.
   task automatic reset_dut(input logic [3:0] r, input logic [3:0] lk, input logic rdy);
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_sel",       32'(bus.sel),       32'd0);
      check("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
      check("rst_ack",       32'(bus.ack),       32'd0);
      m_hold = 1'b0; m_last = 3; m_cnt = 16'd0; m_lwins = 0;
      cq.delete(); dq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(r, lk, rdy);
   endtask

   always @(negedge clk) begin
      cyc_t  c;
      word_t wd;
      if (rst_n) begin
         if (cq.size() == 0) begin
            check("cycle_queue_nonempty", 32'd0, 32'd1);
         end else begin
            c = cq.pop_front();
            check("ack",       32'(bus.ack),       32'(c.ack));
            check("out_valid", 32'(bus.out_valid), 32'(c.vld));
            check("xfer_cnt",  32'(bus.xfer_cnt),  32'(c.cnt));
         end
         if (bus.out_valid) begin
            if (dq.size() == 0) begin
               check("word_queue_nonempty", 32'd0, 32'd1);
            end else begin
               wd = dq[0];
               check(bus.out_ready ? "out_data" : "stall_data", 32'(bus.out_data), 32'(wd.data));
               check(bus.out_ready ? "sel" : "stall_sel",        32'(bus.sel),      32'(wd.sel));
               if (bus.out_ready) void'(dq.pop_front());
            end
         end
      end
   end

   initial begin
      logic [3:0] lk_seq [$];
      logic       pend [4];
      logic [3:0] r;
      bus.req = 4'b0; bus.lock = 4'b0; bus.out_ready = 1'b0;
      bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
      td[0] = 16'h1111; td[1] = 16'h2222; td[2] = 16'h3333; td[3] = 16'h4444;

      // fixed-rotation stream
      reset_dut(4'b1111, 4'b0, 1'b1);
      #1 check("rr_ack0", 32'(bus.ack), 32'h1);
      drive_ack(4'b1111, 4'b0, 1'b1, 4'b0010, "rr_ack1");
      drive_ack(4'b1111, 4'b0, 1'b1, 4'b0100, "rr_ack2");
      drive_ack(4'b1111, 4'b0, 1'b1, 4'b1000, "rr_ack3");
      drive_ack(4'b1111, 4'b0, 1'b1, 4'b0001, "rr_ack4");
      drive(4'b0000, 4'b0, 1'b1);
      check("rr_xfer_cnt4", 32'(bus.xfer_cnt), 32'd4);

      // stalled single word
      td[2] = 16'hBEEF;
      drive_ack(4'b0100, 4'b0, 1'b0, 4'b0100, "stall_capture");
      for (int i = 0; i < 5; i++) drive_ack(4'b0000, 4'b0, 1'b0, 4'b0000, "stall_no_ack");
      drive(4'b0000, 4'b0, 1'b1);
      drive(4'b0000, 4'b0, 1'b0);
      check("stall_back_idle", 32'(bus.out_valid), 32'd0);

      // wrap search from last=1
      drive_ack(4'b0010, 4'b0, 1'b1, 4'b0010, "wrap_set_last1");
      drive_ack(4'b1001, 4'b0, 1'b1, 4'b1000, "wrap_pick3");
      drive_ack(4'b1001, 4'b0, 1'b1, 4'b0001, "wrap_pick0");
      drive(4'b0000, 4'b0, 1'b1);

      // lock behaviour
`ifdef ARB_LOCK_EN
      lk_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
`else
      lk_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
      @(posedge clk); #1;
      reset_dut(4'b0000, 4'b0, 1'b1);
      foreach (lk_seq[i]) drive_ack(4'b0011, 4'b0001, 1'b1, lk_seq[i], "lock_seq");
      drive(4'b0000, 4'b0, 1'b1);

      // random traffic obeying hold-until-ack
      for (int i = 0; i < 4; i++) pend[i] = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               td[i]   = W'($urandom);
            end
         r = {pend[3], pend[2], pend[1], pend[0]};
         apply(r, 4'($urandom), ($urandom_range(0, 3) != 0));
         if (last_win >= 0) pend[last_win] = 1'b0;
      end

      // reset while stalled holding a word
      drive(4'b0100, 4'b0, 1'b0);
      drive(4'b0000, 4'b0, 1'b0);
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
      reset_dut(4'b0010, 4'b0, 1'b1);
      #1 check("post_reset_ack", 32'(bus.ack), 32'h2);
      drive(4'b0000, 4'b0, 1'b1);

      // counter wrap
      @(posedge clk); #1;
      reset_dut(4'b1111, 4'b0, 1'b1);
      for (int i = 1; i <= 65536; i++) begin
         @(posedge clk); #1;
         apply(4'b1111, 4'b0, 1'b1);
         if (i == 65536) check("cnt_ffff", 32'(bus.xfer_cnt), 32'hFFFF);
      end
      @(posedge clk); #1;
      apply(4'b0000, 4'b0, 1'b1);
      check("cnt_wrap0", 32'(bus.xfer_cnt), 32'h0);
      drive(4'b0000, 4'b0, 1'b0);
      drive(4'b0000, 4'b0, 1'b0);
      @(negedge clk); #1;
      check("words_drained", 32'(dq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
